soc_system_video_buffer_arbiter: RTL and testbench



---
 rtl/video_buf_arb_pkg.sv | 15 +
 rtl/soc_system_video_buffer_arbiter.sv | 113 +++++++++++
 tb/tb_soc_system_video_buffer_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_buf_arb_pkg.sv
// Shared defaults and read-owner encoding for the video buffer
// port-s2 arbiter.
package video_buf_arb_pkg;

  localparam int DEPTH_DEF   = 86400;
  localparam int ADDR_W_DEF  = 17;
  localparam int DATA_W_DEF  = 32;
  localparam int A_QUOTA_DEF = 4;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/soc_system_video_buffer_arbiter.sv
// Arbitrates frame buffer port s2 between scanout (A) and AES DMA (B),
// with an A quota so DMA is never starved, and blocks out-of-range access.
module soc_system_video_buffer_arbiter
  import video_buf_arb_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int A_QUOTA = A_QUOTA_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_read,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  input  logic [DATA_W/8-1:0] b_byteenable,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_oob,
  input  logic                err_clear
);

  localparam int Q_W = $clog2(A_QUOTA + 1);
  localparam logic [Q_W-1:0] Q_MAX = Q_W'(A_QUOTA);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic           run_q;
  logic [Q_W-1:0] quota_q;
  logic           rd_pend_q;
  owner_e         rd_own_q;
  logic           rd_oob_q;
  logic           err_q;

  logic req_a, req_b;
  logic grant_a, grant_b, granted;
  logic a_in, b_in, sel_in;
  logic rd_issue;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    req_a   = a_read;
    req_b   = b_read | b_write;
    grant_a = run_q & req_a & (~req_b | (quota_q != '0));
    grant_b = run_q & req_b & ~grant_a;
    granted = grant_a | grant_b;
    a_in    = {1'b0, a_address} < DEPTH_L;
    b_in    = {1'b0, b_address} < DEPTH_L;
    sel_in  = grant_a ? a_in : b_in;
    // b_read together with b_write counts as a write
    rd_issue = grant_a | (grant_b & ~b_write);
  end

  always_comb begin
    a_waitrequest  = ~grant_a;
    b_waitrequest  = ~grant_b;
    mem_address    = grant_b ? b_address : a_address;
    mem_byteenable = grant_b ? b_byteenable : '1;
    mem_writedata  = b_writedata;
    mem_chipselect = granted & sel_in;
    mem_write      = grant_b & b_write & b_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      quota_q   <= Q_MAX;
      rd_pend_q <= 1'b0;
      rd_own_q  <= OWN_A;
      rd_oob_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      rd_pend_q <= rd_issue;
      if (rd_issue) begin
        rd_own_q <= grant_a ? OWN_A : OWN_B;
        rd_oob_q <= ~sel_in;
      end
      if (grant_b | ~req_b) begin
        quota_q <= Q_MAX;
      end else if (grant_a) begin
        quota_q <= quota_q - 1'b1;
      end
      if (err_clear) begin
        err_q <= 1'b0;
      end else if (granted & ~sel_in) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data         = rd_oob_q ? '0 : mem_readdata;
    a_readdata      = rd_data;
    b_readdata      = rd_data;
    a_readdatavalid = rd_pend_q & (rd_own_q == OWN_A);
    b_readdatavalid = rd_pend_q & (rd_own_q == OWN_B);
    err_oob         = err_q;
  end

endmodule

// File: tb/tb_soc_system_video_buffer_arbiter.sv
// Randomized scoreboard bench for the video buffer arbiter with a
// behavioural s2 memory and a rule-level arbitration model.
module tb_soc_system_video_buffer_arbiter;

  localparam int DEPTH   = 86400;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 32;
  localparam int A_QUOTA = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] a_address;
  logic              a_read;
  logic              a_waitrequest;
  logic [DATA_W-1:0] a_readdata;
  logic              a_readdatavalid;
  logic [ADDR_W-1:0] b_address;
  logic              b_read;
  logic              b_write;
  logic [DATA_W-1:0] b_writedata;
  logic [3:0]        b_byteenable;
  logic              b_waitrequest;
  logic [DATA_W-1:0] b_readdata;
  logic              b_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_readdata = '0;
  logic              err_oob;
  logic              err_clear;

  soc_system_video_buffer_arbiter #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .A_QUOTA(A_QUOTA)
  ) dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_read(a_read),
    .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_read(b_read),
    .b_write(b_write), .b_writedata(b_writedata),
    .b_byteenable(b_byteenable),
    .b_waitrequest(b_waitrequest),
    .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata),
    .err_oob(err_oob), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_s(string name, string act, string exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  task automatic flag(string name, int v);
    total++;
    $display("FAIL %s: got event value %0d expected none", name, v);
  endtask

  function automatic logic [31:0] init_word(int a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] wd,
                                        logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // s2 memory seen by the DUT
  logic [31:0] tbm [int];

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        tbm[int'(mem_address)] = merge(
          tbm.exists(int'(mem_address)) ? tbm[int'(mem_address)]
                                        : init_word(int'(mem_address)),
          mem_writedata, mem_byteenable);
      end else begin
        mem_readdata <= tbm.exists(int'(mem_address))
                        ? tbm[int'(mem_address)]
                        : init_word(int'(mem_address));
      end
    end
  end

  // reference model state
  typedef struct {
    logic        own_b;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] shadow [int];
  bit          m_run;
  int          m_streak;
  bit          m_err;

  function automatic logic [31:0] sh_rd(int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  bit          ra, rb, ga, gb, inr, wr, eset;
  int          addr;
  exp_t        e;

  always @(negedge clk) begin
    if (reset) begin
      m_run    = 0;
      m_streak = 0;
      m_err    = 0;
      chk("rst_a_wait", a_waitrequest, 1);
      chk("rst_b_wait", b_waitrequest, 1);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_err", err_oob, 0);
    end else begin
      ra = a_read;
      rb = b_read | b_write;
      ga = 0;
      gb = 0;
      if (m_run) begin
        if (ra && rb) begin
          ga = (m_streak < A_QUOTA);
          gb = !ga;
        end else begin
          ga = ra;
          gb = rb;
        end
      end
      chk("a_wait", a_waitrequest, !ga);
      chk("b_wait", b_waitrequest, !gb);
      chk("err_oob", err_oob, m_err);
      eset = 0;
      if (ga || gb) begin
        addr = ga ? int'(a_address) : int'(b_address);
        inr  = addr < DEPTH;
        wr   = gb && b_write;
        chk("mem_cs", mem_chipselect, inr);
        chk("mem_write", mem_write, wr && inr);
        if (inr) chk("mem_addr", mem_address, addr);
        if (inr) chk("mem_be", mem_byteenable,
                     ga ? 4'hF : b_byteenable);
        if (wr && inr) begin
          chk("mem_wdata", mem_writedata, b_writedata);
          shadow[addr] = merge(sh_rd(addr), b_writedata,
                               b_byteenable);
        end
        if (!wr) begin
          e.own_b = gb;
          e.data  = inr ? sh_rd(addr) : 32'h0;
          e.due   = cyc + 1;
          exp_q.push_back(e);
        end
        eset = !inr;
      end else begin
        chk("idle_cs", mem_chipselect, 0);
      end
      // consecutive A wins while B waits; B gets in once this hits quota
      if (ga && rb) m_streak++;
      else if (gb || !rb) m_streak = 0;
      if (err_clear) m_err = 0;
      else if (eset) m_err = 1;
      m_run = 1;
    end
  end

  logic [31:0] last_a_data, last_b_data;
  int          a_cnt = 0;
  exp_t        p;

  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (a_readdatavalid && b_readdatavalid)
        flag("dual_valid", cyc);
      if (a_readdatavalid || b_readdatavalid) begin
        if (a_readdatavalid) begin
          a_cnt++;
          last_a_data = a_readdata;
        end
        if (b_readdatavalid) last_b_data = b_readdata;
        if (exp_q.size() == 0) begin
          flag("spurious_rdv", cyc);
        end else begin
          p = exp_q.pop_front();
          chk("rdv_cycle", cyc, p.due);
          chk("rdv_owner_b", b_readdatavalid, p.own_b);
          chk("a_rdata", a_readdata, p.data);
          chk("b_rdata", b_readdata, p.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        p = exp_q.pop_front();
        flag("missing_rdv", p.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string gch();
    if (!a_waitrequest) return "A";
    if (!b_waitrequest) return "B";
    return "-";
  endfunction

  task automatic log_cycles(int n, inout string s);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s = {s, gch()};
      step();
    end
  endtask

  function automatic logic [ADDR_W-1:0] raddr();
    if ($urandom_range(0, 9) < 8)
      return ADDR_W'($urandom_range(0, 15));
    return ADDR_W'(DEPTH - 2 + int'($urandom_range(0, 3)));
  endfunction

  string       s;
  logic [31:0] w;
  int          snap;

  initial begin
    reset        = 1;
    a_read       = 1;
    a_address    = 17'h00010;
    b_read       = 0;
    b_write      = 0;
    b_address    = '0;
    b_writedata  = '0;
    b_byteenable = '0;
    err_clear    = 0;

    s = "";
    log_cycles(3, s);
    reset = 0;
    log_cycles(2, s);
    chk_s("reset_release_grant", s, "----A");

    b_read    = 1;
    b_address = 17'h00011;
    s = "";
    log_cycles(20, s);
    chk_s("quota_pattern", s, "AAAABAAAABAAAABAAAAB");

    a_read       = 0;
    b_read       = 0;
    b_write      = 1;
    b_address    = 17'h00020;
    b_writedata  = 32'hCAFE_BABE;
    b_byteenable = 4'b0011;
    last_b_data  = 32'hFFFF_FFFF;
    step();
    b_write = 0;
    b_read  = 1;
    step();
    b_read = 0;
    step();
    w = init_word(32'h20);
    chk("byte_merge", last_b_data, {w[31:16], 16'hBABE});

    b_write      = 1;
    b_address    = 17'(DEPTH);
    b_writedata  = 32'h1234_5678;
    b_byteenable = 4'hF;
    @(negedge clk);
    chk("oob_write_cs", mem_chipselect, 0);
    step();
    b_write     = 0;
    a_read      = 1;
    a_address   = 17'h15180;
    last_a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("oob_err_set", err_oob, 1);
    step();
    a_read = 0;
    step();
    chk("oob_read_zero", last_a_data, 0);
    err_clear = 1;
    step();
    err_clear = 0;
    @(negedge clk);
    chk("err_cleared", err_oob, 0);
    step();

    a_read    = 1;
    a_address = 17'h00003;
    s = "";
    log_cycles(10, s);
    b_read    = 1;
    b_address = 17'h00004;
    log_cycles(5, s);
    chk_s("a_only_then_shared", s, "AAAAAAAAAAAAAAB");
    b_read = 0;

    a_address = 17'h00005;
    step();
    snap   = a_cnt;
    reset  = 1;
    a_read = 0;
    step();
    step();
    reset = 0;
    repeat (4) step();
    chk("no_rdv_after_reset", a_cnt, snap);

    for (int i = 0; i < 400; i++) begin
      a_read       = ($urandom_range(0, 3) != 0);
      a_address    = raddr();
      b_read       = $urandom_range(0, 1);
      b_write      = ($urandom_range(0, 2) == 0);
      b_address    = raddr();
      b_writedata  = $urandom;
      b_byteenable = 4'($urandom_range(0, 15));
      err_clear    = ($urandom_range(0, 15) == 0);
      step();
    end
    a_read    = 0;
    b_read    = 0;
    b_write   = 0;
    err_clear = 0;
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
